// File: rtl/fpga_mode_sel.sv
// HF/LF design select for the output muxes. The switch pin is synchronised and debounced.
// A select swap happens only while the coil drivers are held quiet on both sides of it.
module fpga_mode_sel #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int GUARD_CYCLES    = 64,
    parameter int CNT_W           = 16
) (
    input  logic ck_1356meg,
    input  logic nreset,
    input  logic fpga_switch_raw,
    output logic sel_hf,
    output logic drv_quiet,
    output logic busy,
    output logic mode_changed
);

    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_STARTUP,
        ST_IDLE,
        ST_DEBOUNCE,
        ST_QUIESCE,
        ST_SWAP,
        ST_SETTLE
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sw_s;
    logic                   sw_prev_q;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_q, sel_d;
    logic             quiet_q, quiet_d;
    logic             busy_q, busy_d;
    logic             mc_q, mc_d;
    logic             swapped_q, swapped_d;

    assign sw_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge ck_1356meg) begin
        if (!nreset) begin
            sync_q    <= '0;
            sw_prev_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], fpga_switch_raw};
            sw_prev_q <= sw_s;
        end
    end

    // Outputs are registered from the next state, so each changes on the edge that enters its state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        swapped_d = swapped_q;
        mc_d      = 1'b0;
        case (state_q)
            ST_STARTUP: begin
                if (sw_s != sw_prev_q) begin
                    cnt_d = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d   = ST_SETTLE;
                    sel_d     = sw_s;
                    swapped_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_IDLE: begin
                if (sw_s != sel_q) state_d = ST_DEBOUNCE;
            end
            ST_DEBOUNCE: begin
                if (sw_s == sel_q)          state_d = ST_IDLE;
                else if (cnt_q == DEB_LAST) state_d = ST_QUIESCE;
                else                        cnt_d   = cnt_q + CNT_ONE;
            end
            ST_QUIESCE: begin
                if (cnt_q == GUARD_LAST) begin
                    state_d   = ST_SWAP;
                    sel_d     = ~sel_q;
                    swapped_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_SWAP: begin
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == GUARD_LAST) begin
                    state_d   = ST_IDLE;
                    mc_d      = swapped_q;
                    swapped_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_STARTUP;
            end
        endcase
        if (state_d != state_q) cnt_d = '0;
        quiet_d = (state_d != ST_IDLE) && (state_d != ST_DEBOUNCE);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge ck_1356meg) begin
        if (!nreset) begin
            state_q   <= ST_STARTUP;
            cnt_q     <= '0;
            sel_q     <= 1'b0;
            quiet_q   <= 1'b1;
            busy_q    <= 1'b1;
            mc_q      <= 1'b0;
            swapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            quiet_q   <= quiet_d;
            busy_q    <= busy_d;
            mc_q      <= mc_d;
            swapped_q <= swapped_d;
        end
    end

    assign sel_hf       = sel_q;
    assign drv_quiet    = quiet_q;
    assign busy         = busy_q;
    assign mode_changed = mc_q;

endmodule

// File: tb/tb_fpga_mode_sel.sv
// Bench for fpga_mode_sel: directed handover scenarios plus randomised switch toggling,
// all compared against a timestamp-based reference model of the handover rules.
module tb_fpga_mode_sel;

    localparam int D = 8;
    localparam int G = 4;

    logic clk = 1'b0;
    logic nreset;
    logic raw;
    logic sel_hf, drv_quiet, busy, mode_changed;

    always #5 clk = ~clk;

    fpga_mode_sel #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(D),
        .GUARD_CYCLES   (G),
        .CNT_W          (16)
    ) dut (
        .ck_1356meg     (clk),
        .nreset         (nreset),
        .fpga_switch_raw(raw),
        .sel_hf         (sel_hf),
        .drv_quiet      (drv_quiet),
        .busy           (busy),
        .mode_changed   (mode_changed)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n     = 0;

    task automatic expect_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (edge %0d)", tag, obs, exp, n);
        end
    endtask

    // Reference model: synchroniser as a plain shift of samples, handover as scheduled edge numbers.
    bit m_sync0 = 0, m_sync1 = 0, m_prev = 0;
    bit m_sel = 0, m_quiet = 1, m_busy = 1, m_mc = 0, m_start = 1, m_pulse = 0;
    int m_run = 0, m_streak = 0, m_swap_at = -1, m_end_at = -1;

    task automatic model_step(input bit rst_n, input bit r);
        bit sw, pv;
        sw   = m_sync1;
        pv   = m_prev;
        m_mc = 0;
        if (!rst_n) begin
            m_sync0 = 0; m_sync1 = 0; m_prev = 0;
            m_sel = 0; m_quiet = 1; m_busy = 1; m_start = 1;
            m_run = 0; m_streak = 0; m_swap_at = -1; m_end_at = -1; m_pulse = 0;
        end else begin
            if (m_start) begin
                m_run = (sw == pv) ? m_run + 1 : 0;
                if (m_run == D) begin
                    m_start = 0; m_sel = sw; m_swap_at = -1; m_end_at = n + G; m_pulse = 0;
                end
            end else if (m_end_at >= 0) begin
                if (n == m_swap_at) m_sel = !m_sel;
                if (n == m_end_at) begin
                    m_quiet = 0; m_busy = 0; m_mc = m_pulse; m_end_at = -1; m_streak = 0;
                end
            end else begin
                m_streak = (sw != m_sel) ? m_streak + 1 : 0;
                if (m_streak == D + 1) begin
                    m_quiet = 1; m_busy = 1; m_pulse = 1; m_streak = 0;
                    m_swap_at = n + G;
                    m_end_at  = n + 2 * G + 1;
                end else begin
                    m_quiet = 0;
                    m_busy  = (m_streak > 0);
                end
            end
            m_prev = m_sync1; m_sync1 = m_sync0; m_sync0 = r;
        end
    endtask

    // Event watch: 1-based tick indices of first transitions since watch_clear.
    int w_idx, w_sel_edge, w_sel_n, w_qrise, w_qfall, w_mc, w_busy;
    logic w_last_sel, w_last_q;

    task automatic watch_clear();
        w_idx = 0; w_sel_edge = -1; w_sel_n = 0; w_qrise = -1; w_qfall = -1;
        w_mc = 0; w_busy = 0;
        w_last_sel = sel_hf; w_last_q = drv_quiet;
    endtask

    // Quiet-window invariant tracking.
    bit   inv_on = 0;
    bit   inv_post = 0;
    int   q_run = 0;
    int   edge_n = 0;
    logic inv_last_sel = 1'b0;

    task automatic tick();
        @(posedge clk);
        n++;
        model_step(nreset, raw);
        #1;
        expect_eq("sel_hf", int'(sel_hf), int'(m_sel));
        expect_eq("drv_quiet", int'(drv_quiet), int'(m_quiet));
        expect_eq("busy", int'(busy), int'(m_busy));
        expect_eq("mode_changed", int'(mode_changed), int'(m_mc));

        w_idx++;
        if (sel_hf !== w_last_sel) begin
            w_sel_n++;
            if (w_sel_edge < 0) w_sel_edge = w_idx;
        end
        if (drv_quiet && !w_last_q && w_qrise < 0) w_qrise = w_idx;
        if (!drv_quiet && w_last_q && w_qfall < 0) w_qfall = w_idx;
        if (mode_changed) w_mc++;
        if (busy) w_busy++;
        w_last_sel = sel_hf;
        w_last_q   = drv_quiet;

        q_run = drv_quiet ? q_run + 1 : 0;
        if (sel_hf !== inv_last_sel) begin
            if (inv_on) begin
                expect_eq("quiet_at_sel_edge", int'(drv_quiet), 1);
                expect_eq("quiet_before_edge", int'(q_run - 1 >= G), 1);
            end
            edge_n   = n;
            inv_post = 1;
        end
        if (!drv_quiet && inv_post) begin
            if (inv_on) expect_eq("quiet_after_edge", int'(n - edge_n - 1 >= G), 1);
            inv_post = 0;
        end
        inv_last_sel = sel_hf;
    endtask

    // raw changes just after tick 0; sw_s follows at tick 2, so latencies are offset by 2.
    task automatic handover_run(input logic lvl, input string tag);
        watch_clear();
        raw = lvl;
        repeat (40) tick();
        expect_eq({tag, "_qrise"}, w_qrise, D + 3);
        expect_eq({tag, "_sel_edge"}, w_sel_edge, D + G + 3);
        expect_eq({tag, "_qfall"}, w_qfall, D + 2 * G + 4);
        expect_eq({tag, "_mc_pulses"}, w_mc, 1);
        expect_eq({tag, "_sel"}, int'(sel_hf), int'(lvl));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        int k;
        int left;
        int hold;
        nreset = 1'b0;
        raw    = 1'b1;
        repeat (3) tick();
        expect_eq("rst_sel", int'(sel_hf), 0);
        expect_eq("rst_quiet", int'(drv_quiet), 1);
        expect_eq("rst_busy", int'(busy), 1);
        expect_eq("rst_mc", int'(mode_changed), 0);

        // Start-up acquisition of HF with the pin held high.
        nreset = 1'b1;
        watch_clear();
        repeat (30) tick();
        expect_eq("su_sel_edge", w_sel_edge, D + 3);
        expect_eq("su_qfall", w_qfall, D + 3 + G);
        expect_eq("su_mc", w_mc, 0);
        expect_eq("su_sel", int'(sel_hf), 1);

        handover_run(1'b0, "ho_hf2lf");
        handover_run(1'b1, "ho_lf2hf");

        // Glitches against the current HF selection.
        for (int L = 1; L <= 5; L += 4) begin
            watch_clear();
            raw = 1'b0;
            repeat (L) tick();
            raw = 1'b1;
            repeat (30) tick();
            expect_eq("glitch_busy", w_busy, L);
            expect_eq("glitch_mc", w_mc, 0);
            expect_eq("glitch_sel_edge", w_sel_edge, -1);
            expect_eq("glitch_qrise", w_qrise, -1);
        end

        // Pin reverts while the first handover settles: two complete handovers.
        watch_clear();
        raw = 1'b0;
        repeat (17) tick();
        raw = 1'b1;
        repeat (60) tick();
        expect_eq("rev_mc_pulses", w_mc, 2);
        expect_eq("rev_sel_edges", w_sel_n, 2);
        expect_eq("rev_sel", int'(sel_hf), 1);

        // Reset on the SWAP cycle of an LF->HF handover.
        raw = 1'b0;
        repeat (40) tick();
        watch_clear();
        raw = 1'b1;
        k = 0;
        while (sel_hf !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        expect_eq("swap_reached", int'(sel_hf), 1);
        nreset = 1'b0;
        tick();
        expect_eq("swrst_sel", int'(sel_hf), 0);
        expect_eq("swrst_quiet", int'(drv_quiet), 1);
        expect_eq("swrst_busy", int'(busy), 1);
        expect_eq("swrst_mc", int'(mode_changed), 0);
        nreset = 1'b1;
        watch_clear();
        repeat (30) tick();
        expect_eq("swrst_sel_edge", w_sel_edge, D + 3);
        expect_eq("swrst_mc_pulses", w_mc, 0);
        expect_eq("swrst_sel_final", int'(sel_hf), 1);
        expect_eq("swrst_quiet_final", int'(drv_quiet), 0);

        // Randomised pin activity with short glitches and long holds.
        inv_post = 0;
        inv_last_sel = sel_hf;
        inv_on = 1;
        left = 10000;
        while (left > 0) begin
            raw  = ~raw;
            hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6))
                                               : int'($urandom_range(8, 40));
            repeat (hold) tick();
            left -= hold;
        end
        inv_on = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fpga_mode_sel.md
Name: fpga_mode_sel

Overview:
- Upstream control stage that produces the HF/LF select driving the top-level output muxes on the iCopy-X build.
- Synchronises and debounces the raw FPGA_SWITCH pin.
- Changes the select only inside a quiet window: coil drivers are gated off before the swap and held off while the newly selected design settles.
- Prevents glitches on pwr_*, ssp_* and adc_clk during a HF/LF handover.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchroniser (min 2).
- DEBOUNCE_CYCLES, 1024, consecutive stable cycles required before a new switch level is accepted (min 2).
- GUARD_CYCLES, 64, length of each quiet window, before and after the swap (min 1).
- CNT_W, 16, width of the shared counter; must hold max(DEBOUNCE_CYCLES, GUARD_CYCLES).

Ports:
- ck_1356meg  input  1  block clock.
- nreset  input  1  synchronous, active-low reset.
- fpga_switch_raw  input  1  asynchronous FPGA_SWITCH pin; 1 = HF requested.
- sel_hf  output  1  registered mux select to the output muxes; 1 = HF design, 0 = LF design.
- drv_quiet  output  1  registered; 1 forces pwr_lo/pwr_hi/pwr_oe1-4/PWR_LO_EN low and ssp_frame/ssp_clk low downstream.
- busy  output  1  registered; 1 whenever the state is not IDLE.
- mode_changed  output  1  registered one-cycle pulse when a handover completes.

Behaviour:
- Synchroniser:
  - SYNC_STAGES flops; sw_s = last stage.
  - Synchroniser flops reset to 0.
- Counter: cnt is CNT_W bits, shared by all states, cleared on every state entry.
- Reset (nreset=0 at a clock edge), regardless of current state:
  - sel_hf=0, drv_quiet=1, busy=1, mode_changed=0, cnt=0, state=STARTUP.
- STARTUP:
  - cnt increments while sw_s equals its value on the previous cycle; cnt clears on any change.
  - When cnt reaches DEBOUNCE_CYCLES-1: sel_hf<=sw_s, go to SETTLE. No mode_changed pulse.
- IDLE:
  - drv_quiet=0, busy=0.
  - If sw_s != sel_hf, go to DEBOUNCE.
- DEBOUNCE:
  - busy=1, drv_quiet=0.
  - cnt increments each cycle while sw_s != sel_hf.
  - If sw_s == sel_hf at any cycle, abort to IDLE with no output change.
  - When cnt reaches DEBOUNCE_CYCLES-1 with sw_s still != sel_hf, go to QUIESCE.
- QUIESCE:
  - drv_quiet=1.
  - Runs for GUARD_CYCLES cycles, then goes to SWAP.
  - sw_s is ignored.
- SWAP:
  - Exactly 1 cycle: sel_hf <= ~sel_hf; drv_quiet stays 1.
  - Then go to SETTLE.
- SETTLE:
  - drv_quiet=1, sw_s ignored.
  - After GUARD_CYCLES cycles, go to IDLE.
  - mode_changed=1 for the single cycle on which the state register becomes IDLE, only if entered from SWAP.
- Invariants:
  - sel_hf never changes while drv_quiet=0.
  - drv_quiet is 1 for at least GUARD_CYCLES cycles on each side of a sel_hf edge.
- Latency: from the first edge where sw_s differs from sel_hf and stays stable:
  - drv_quiet rises after DEBOUNCE_CYCLES+1 cycles.
  - sel_hf toggles after DEBOUNCE_CYCLES+GUARD_CYCLES+1 cycles.
  - drv_quiet falls after DEBOUNCE_CYCLES+2*GUARD_CYCLES+2 cycles.
  - Counted in ck_1356meg cycles, excluding synchroniser delay.
- Switch change during QUIESCE/SWAP/SETTLE: no effect on the current sequence. IDLE re-evaluates it afterwards, so a reversal causes a second full handover.
- Counter never wraps: comparisons use == on terminal values, and cnt clears on every state entry.
- Reset mid-handover: outputs return to reset values on the same edge, including sel_hf=0 even if it was 1. The STARTUP path then re-acquires the pin level while drv_quiet stays 1.

Test Plan (bench uses DEBOUNCE_CYCLES=8, GUARD_CYCLES=4, SYNC_STAGES=2):
- Reset, raw=1 held → drv_quiet=1 throughout; sel_hf=1 after 8 stable cycles; drv_quiet=0 four cycles later; no mode_changed pulse.
- From IDLE with sel_hf=0, raw 0→1 held → drv_quiet rises 9 cycles after sw_s changes; sel_hf toggles at cycle 13; drv_quiet falls at cycle 18; single mode_changed pulse.
- Raw 1-cycle and 5-cycle glitches from IDLE → DEBOUNCE aborts; sel_hf, drv_quiet and mode_changed unchanged; busy high only during the glitch.
- Raw toggled back to the old level during SETTLE → first handover completes; a second full handover returns sel_hf to the old value; two mode_changed pulses.
- nreset asserted during SWAP with sel_hf=1 and raw=1 → next edge sel_hf=0, drv_quiet=1; re-acquires sel_hf=1 via STARTUP.
- Randomised raw toggling for 10k cycles → assertion: no sel_hf edge while drv_quiet=0, and drv_quiet held for ≥4 cycles before and after every sel_hf edge.
